// File: rtl/core_launcher.sv
`default_nettype none
// ============================================================================
// core_launcher : loads operands into core data memory, pulses start, waits
//                 for done under a cycle timeout, then streams results out.
// Revision      : 1.0
// ============================================================================
module core_launcher #(
    parameter logic [7:0] IN_BASE      = 8'h00,
    parameter int         IN_WORDS     = 2,
    parameter logic [7:0] OUT_BASE     = 8'h08,
    parameter int         OUT_WORDS    = 4,
    parameter int         START_CYCLES = 2,
    parameter int         DONE_MASK    = 2,
    parameter int         TIMEOUT      = 1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_data,
    output logic        start,
    input  logic        done,
    output logic        mem_wr_en,
    output logic [7:0]  mem_addr,
    output logic [7:0]  mem_wr_data,
    input  logic [7:0]  mem_rd_data,
    output logic        busy,
    output logic        timed_out,
    output logic [15:0] run_cycles
);

    localparam logic [4:0]  c_IN_LAST    = 5'(IN_WORDS - 1);
    localparam logic [4:0]  c_OUT_LAST   = 5'(OUT_WORDS - 1);
    localparam logic [15:0] c_START_LAST = 16'(START_CYCLES - 1);
    localparam logic [15:0] c_DONE_MASK  = 16'(DONE_MASK);
    localparam logic [15:0] c_TIMEOUT    = 16'(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_START = 3'd2,
        S_RUN   = 3'd3,
        S_READ  = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_state_n;
    logic [4:0]  r_idx;
    logic [4:0]  w_idx_n;
    logic [15:0] r_scnt;
    logic [15:0] w_scnt_n;
    logic [15:0] r_run;
    logic [15:0] w_run_n;
    logic [15:0] w_run_inc;
    logic        r_timed_out;
    logic        w_timed_out_n;
    logic        w_done_ok;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_idx       <= 5'd0;
            r_scnt      <= 16'd0;
            r_run       <= 16'd0;
            r_timed_out <= 1'b0;
        end else begin
            r_state     <= w_state_n;
            r_idx       <= w_idx_n;
            r_scnt      <= w_scnt_n;
            r_run       <= w_run_n;
            r_timed_out <= w_timed_out_n;
        end
    end

    // A done level left over from the previous run is only trusted once the
    // mask window at the head of RUN has elapsed.
    assign w_run_inc = (r_run == 16'hFFFF) ? r_run : r_run + 16'd1;
    assign w_done_ok = done && (r_run >= c_DONE_MASK);

    always_comb begin
        w_state_n     = r_state;
        w_idx_n       = r_idx;
        w_scnt_n      = r_scnt;
        w_run_n       = r_run;
        w_timed_out_n = r_timed_out;
        in_ready      = 1'b0;
        out_valid     = 1'b0;
        out_data      = 8'h00;
        start         = 1'b0;
        mem_wr_en     = 1'b0;
        mem_addr      = 8'h00;
        mem_wr_data   = 8'h00;

        case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    w_state_n     = S_LOAD;
                    w_timed_out_n = 1'b0;
                end
            end
            S_LOAD: begin
                in_ready = 1'b1;
                mem_addr = IN_BASE + {3'b000, r_idx};
                if (in_valid) begin
                    mem_wr_en   = 1'b1;
                    mem_wr_data = in_data;
                    if (r_idx == c_IN_LAST) begin
                        w_idx_n   = 5'd0;
                        w_scnt_n  = 16'd0;
                        w_run_n   = 16'd0;
                        w_state_n = S_START;
                    end else begin
                        w_idx_n = r_idx + 5'd1;
                    end
                end
            end
            S_START: begin
                start = 1'b1;
                if (r_scnt == c_START_LAST) begin
                    w_scnt_n  = 16'd0;
                    w_state_n = S_RUN;
                end else begin
                    w_scnt_n = r_scnt + 16'd1;
                end
            end
            S_RUN: begin
                w_run_n = w_run_inc;
                // A qualifying done takes priority over a coincident timeout.
                if (w_done_ok) begin
                    w_state_n = S_READ;
                end else if (w_run_inc >= c_TIMEOUT) begin
                    w_timed_out_n = 1'b1;
                    w_state_n     = S_IDLE;
                end
            end
            S_READ: begin
                out_valid = 1'b1;
                mem_addr  = OUT_BASE + {3'b000, r_idx};
                out_data  = mem_rd_data;
                if (out_ready) begin
                    if (r_idx == c_OUT_LAST) begin
                        w_idx_n   = 5'd0;
                        w_state_n = S_IDLE;
                    end else begin
                        w_idx_n = r_idx + 5'd1;
                    end
                end
            end
            default: begin
                w_state_n = S_IDLE;
                w_idx_n   = 5'd0;
            end
        endcase
    end

    assign busy       = (r_state != S_IDLE);
    assign timed_out  = r_timed_out;
    assign run_cycles = r_run;

endmodule
`default_nettype wire

// File: tb/tb_core_launcher.sv
`default_nettype none
// ============================================================================
// tb_core_launcher : scoreboard bench for core_launcher (two instances, the
//                    second with wrapping base addresses).
// Revision         : 1.0
// ============================================================================
module tb_core_launcher;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        out_ready;
    logic        done;

    logic        in_ready,    in_ready_b;
    logic        out_valid,   out_valid_b;
    logic [7:0]  out_data,    out_data_b;
    logic        start,       start_b;
    logic        mem_wr_en,   mem_wr_en_b;
    logic [7:0]  mem_addr,    mem_addr_b;
    logic [7:0]  mem_wr_data, mem_wr_data_b;
    logic [7:0]  mem_rd_data, mem_rd_data_b;
    logic        busy,        busy_b;
    logic        timed_out,   timed_out_b;
    logic [15:0] run_cycles,  run_cycles_b;

    logic [7:0]  mem   [256];
    logic [7:0]  mem_b [256];

    logic [15:0] exp_wr_q[$];
    logic [7:0]  exp_rd_q[$];
    logic [15:0] exp_wr_b_q[$];
    logic [7:0]  exp_rd_b_q[$];

    int checks = 0;
    int errors = 0;

    assign mem_rd_data   = mem[mem_addr];
    assign mem_rd_data_b = mem_b[mem_addr_b];

    always #5 clk = ~clk;

    core_launcher dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .start(start), .done(done),
        .mem_wr_en(mem_wr_en), .mem_addr(mem_addr), .mem_wr_data(mem_wr_data),
        .mem_rd_data(mem_rd_data),
        .busy(busy), .timed_out(timed_out), .run_cycles(run_cycles)
    );

    core_launcher #(.IN_BASE(8'hFF), .OUT_BASE(8'hFE)) dut_b (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready_b), .in_data(in_data),
        .out_valid(out_valid_b), .out_ready(out_ready), .out_data(out_data_b),
        .start(start_b), .done(done),
        .mem_wr_en(mem_wr_en_b), .mem_addr(mem_addr_b), .mem_wr_data(mem_wr_data_b),
        .mem_rd_data(mem_rd_data_b),
        .busy(busy_b), .timed_out(timed_out_b), .run_cycles(run_cycles_b)
    );

    // Memory model: commits a write seen in the current cycle.
    task automatic mem_update();
        if (mem_wr_en)   mem[mem_addr]     = mem_wr_data;
        if (mem_wr_en_b) mem_b[mem_addr_b] = mem_wr_data_b;
    endtask

    task automatic test_reset();
        @(negedge clk);
        #1;
        checks++;
        if ({in_ready, out_valid, start, mem_wr_en, mem_addr, mem_wr_data, busy, timed_out, run_cycles} !== 38'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h required 0", {in_ready, out_valid, start, mem_wr_en, mem_addr, mem_wr_data, busy, timed_out, run_cycles});
        end
        checks++;
        if ({in_ready_b, out_valid_b, start_b, mem_wr_en_b, mem_addr_b, busy_b} !== 13'd0) begin
            errors++;
            $display("FAIL reset_outputs_b: got %h required 0", {in_ready_b, out_valid_b, start_b, mem_wr_en_b, mem_addr_b, busy_b});
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: busy=%b in_ready=%b required 0 0", busy, in_ready);
        end
    endtask

    task automatic test_nominal();
        logic [7:0]  nb [2];
        logic [15:0] exp_w;
        logic [7:0]  exp_r;
        int          sent = 0;
        nb[0] = 8'h3C;
        nb[1] = 8'h81;
        for (int i = 0; i < 4; i++) begin
            mem[8 + i] = 8'(i + 1);
            exp_rd_q.push_back(8'(i + 1));
        end
        exp_wr_q.push_back({8'h00, 8'h3C});
        exp_wr_q.push_back({8'h01, 8'h81});
        for (int c = 0; c < 24; c++) begin
            @(negedge clk);
            in_valid  = (sent < 2);
            in_data   = (sent < 2) ? nb[sent] : 8'h00;
            done      = (c >= 16);
            out_ready = 1'b1;
            #1;
            mem_update();
            if (mem_wr_en) begin
                checks++;
                exp_w = (exp_wr_q.size() != 0) ? exp_wr_q.pop_front() : 16'hxxxx;
                if ({mem_addr, mem_wr_data} !== exp_w) begin
                    errors++;
                    $display("FAIL nominal_wr c=%0d: got %h required %h", c, {mem_addr, mem_wr_data}, exp_w);
                end
            end
            if (in_valid && in_ready) sent++;
            checks++;
            if (start !== (c == 3 || c == 4) || (start && mem_wr_en)) begin
                errors++;
                $display("FAIL nominal_start c=%0d: got %b (wr %b) required %b", c, start, mem_wr_en, (c == 3 || c == 4));
            end
            checks++;
            if (out_valid !== (c >= 17 && c <= 20)) begin
                errors++;
                $display("FAIL nominal_out_valid c=%0d: got %b required %b", c, out_valid, (c >= 17 && c <= 20));
            end
            if (out_valid && out_ready) begin
                checks++;
                exp_r = (exp_rd_q.size() != 0) ? exp_rd_q.pop_front() : 8'hxx;
                if (out_data !== exp_r) begin
                    errors++;
                    $display("FAIL nominal_rd c=%0d: got %h required %h", c, out_data, exp_r);
                end
            end
            checks++;
            if (busy !== (c >= 1 && c <= 20)) begin
                errors++;
                $display("FAIL nominal_busy c=%0d: got %b required %b", c, busy, (c >= 1 && c <= 20));
            end
        end
        done     = 1'b0;
        in_valid = 1'b0;
        checks++;
        if (run_cycles !== 16'd12) begin
            errors++;
            $display("FAIL nominal_run_cycles: got %0d required 12", run_cycles);
        end
        checks++;
        if (exp_wr_q.size() != 0 || exp_rd_q.size() != 0 || timed_out !== 1'b0) begin
            errors++;
            $display("FAIL nominal_leftover: wr=%0d rd=%0d timed_out=%b required 0 0 0", exp_wr_q.size(), exp_rd_q.size(), timed_out);
        end
        exp_wr_q.delete();
        exp_rd_q.delete();
    endtask

    task automatic test_stale_done();
        logic [7:0] exp_r;
        int         sent = 0;
        for (int i = 0; i < 4; i++) begin
            mem[8 + i] = 8'hA1 + 8'(i * 17);
            exp_rd_q.push_back(8'hA1 + 8'(i * 17));
        end
        for (int c = 0; c < 18; c++) begin
            @(negedge clk);
            in_valid  = (sent < 2);
            in_data   = 8'h11 + 8'(sent * 17);
            done      = (c >= 3 && c <= 6) || (c >= 10);
            out_ready = 1'b1;
            #1;
            mem_update();
            if (in_valid && in_ready) sent++;
            checks++;
            if (out_valid !== (c >= 11 && c <= 14)) begin
                errors++;
                $display("FAIL stale_out_valid c=%0d: got %b required %b", c, out_valid, (c >= 11 && c <= 14));
            end
            if (out_valid && out_ready) begin
                checks++;
                exp_r = (exp_rd_q.size() != 0) ? exp_rd_q.pop_front() : 8'hxx;
                if (out_data !== exp_r) begin
                    errors++;
                    $display("FAIL stale_rd c=%0d: got %h required %h", c, out_data, exp_r);
                end
            end
        end
        done     = 1'b0;
        in_valid = 1'b0;
        checks++;
        if (run_cycles !== 16'd6 || exp_rd_q.size() != 0) begin
            errors++;
            $display("FAIL stale_run_cycles: got %0d (left %0d) required 6 (0)", run_cycles, exp_rd_q.size());
        end
        exp_rd_q.delete();
    endtask

    task automatic test_timeout();
        logic [7:0] exp_r;
        int         sent = 0;
        int         reads = 0;
        for (int c = 0; c < 1010; c++) begin
            @(negedge clk);
            in_valid  = (sent < 2);
            in_data   = 8'h55;
            done      = 1'b0;
            out_ready = 1'b1;
            #1;
            mem_update();
            if (in_valid && in_ready) sent++;
            checks++;
            if (busy !== (c >= 1 && c <= 1004) || out_valid !== 1'b0 || timed_out !== (c >= 1005)) begin
                errors++;
                $display("FAIL timeout_seq c=%0d: busy=%b out_valid=%b timed_out=%b required %b 0 %b", c, busy, out_valid, timed_out, (c >= 1 && c <= 1004), (c >= 1005));
            end
        end
        checks++;
        if (run_cycles !== 16'd1000) begin
            errors++;
            $display("FAIL timeout_run_cycles: got %0d required 1000", run_cycles);
        end
        for (int i = 0; i < 4; i++) exp_rd_q.push_back(mem[8 + i]);
        sent = 0;
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            in_valid  = (sent < 2);
            in_data   = 8'h77;
            done      = (c >= 7);
            out_ready = 1'b1;
            #1;
            mem_update();
            if (in_valid && in_ready) sent++;
            if (c <= 1) begin
                checks++;
                if (timed_out !== (c == 0)) begin
                    errors++;
                    $display("FAIL timeout_clear c=%0d: got %b required %b", c, timed_out, (c == 0));
                end
            end
            if (out_valid && out_ready) begin
                checks++;
                reads++;
                exp_r = (exp_rd_q.size() != 0) ? exp_rd_q.pop_front() : 8'hxx;
                if (out_data !== exp_r) begin
                    errors++;
                    $display("FAIL timeout_relaunch_rd c=%0d: got %h required %h", c, out_data, exp_r);
                end
            end
        end
        done     = 1'b0;
        in_valid = 1'b0;
        checks++;
        if (reads != 4 || run_cycles !== 16'd3 || timed_out !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL timeout_relaunch: reads=%0d run=%0d timed_out=%b busy=%b required 4 3 0 0", reads, run_cycles, timed_out, busy);
        end
        exp_rd_q.delete();
    endtask

    task automatic test_backpressure();
        logic [6:0]  orp = 7'b1110100;   // bit i drives out_ready on READ cycle i
        logic [3:0]  ivp = 4'b1011;      // bit c drives in_valid on cycle c
        logic [7:0]  nb [2];
        logic [15:0] exp_w;
        logic [7:0]  exp_r;
        logic [7:0]  prev_data = 8'h00;
        logic        prev_stall = 1'b0;
        int          sent = 0;
        int          writes = 0;
        int          reads = 0;
        nb[0] = 8'hB7;
        nb[1] = 8'h4E;
        for (int i = 0; i < 4; i++) begin
            mem[8 + i] = 8'h5A + 8'(i * 17);
            exp_rd_q.push_back(8'h5A + 8'(i * 17));
        end
        exp_wr_q.push_back({8'h00, 8'hB7});
        exp_wr_q.push_back({8'h01, 8'h4E});
        for (int c = 0; c < 19; c++) begin
            @(negedge clk);
            in_valid  = (c < 4) ? ivp[c] : 1'b0;
            in_data   = (sent < 2) ? nb[sent] : 8'h00;
            done      = (c >= 8);
            out_ready = (c >= 9 && c <= 15) ? orp[c - 9] : 1'b0;
            #1;
            mem_update();
            if (mem_wr_en) begin
                checks++;
                writes++;
                exp_w = (exp_wr_q.size() != 0) ? exp_wr_q.pop_front() : 16'hxxxx;
                if ({mem_addr, mem_wr_data} !== exp_w) begin
                    errors++;
                    $display("FAIL bp_wr c=%0d: got %h required %h", c, {mem_addr, mem_wr_data}, exp_w);
                end
            end
            if (in_valid && in_ready) sent++;
            checks++;
            if (out_valid !== (c >= 9 && c <= 15)) begin
                errors++;
                $display("FAIL bp_out_valid c=%0d: got %b required %b", c, out_valid, (c >= 9 && c <= 15));
            end
            if (prev_stall && out_valid) begin
                checks++;
                if (out_data !== prev_data) begin
                    errors++;
                    $display("FAIL bp_stable c=%0d: got %h required %h", c, out_data, prev_data);
                end
            end
            if (out_valid && out_ready) begin
                checks++;
                reads++;
                exp_r = (exp_rd_q.size() != 0) ? exp_rd_q.pop_front() : 8'hxx;
                if (out_data !== exp_r) begin
                    errors++;
                    $display("FAIL bp_rd c=%0d: got %h required %h", c, out_data, exp_r);
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
        end
        done      = 1'b0;
        out_ready = 1'b1;
        checks++;
        if (writes != 2 || reads != 4 || busy !== 1'b0) begin
            errors++;
            $display("FAIL bp_counts: writes=%0d reads=%0d busy=%b required 2 4 0", writes, reads, busy);
        end
        exp_wr_q.delete();
        exp_rd_q.delete();
    endtask

    task automatic test_addr_wrap();
        logic [15:0] exp_w;
        logic [7:0]  exp_r;
        int          sent = 0;
        mem_b[8'hFE] = 8'hE0;
        mem_b[8'h01] = 8'hE3;
        exp_wr_b_q.push_back({8'hFF, 8'hC1});
        exp_wr_b_q.push_back({8'h00, 8'hC2});
        exp_rd_b_q.push_back(8'hE0);
        exp_rd_b_q.push_back(8'hC1);
        exp_rd_b_q.push_back(8'hC2);
        exp_rd_b_q.push_back(8'hE3);
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            in_valid  = (sent < 2);
            in_data   = 8'hC1 + 8'(sent);
            done      = (c >= 7);
            out_ready = 1'b1;
            #1;
            if (mem_wr_en_b) begin
                checks++;
                exp_w = (exp_wr_b_q.size() != 0) ? exp_wr_b_q.pop_front() : 16'hxxxx;
                if ({mem_addr_b, mem_wr_data_b} !== exp_w) begin
                    errors++;
                    $display("FAIL wrap_wr c=%0d: got %h required %h", c, {mem_addr_b, mem_wr_data_b}, exp_w);
                end
            end
            mem_update();
            if (in_valid && in_ready_b) sent++;
            checks++;
            if (out_valid_b !== (c >= 8 && c <= 11)) begin
                errors++;
                $display("FAIL wrap_out_valid c=%0d: got %b required %b", c, out_valid_b, (c >= 8 && c <= 11));
            end
            if (out_valid_b && out_ready) begin
                checks++;
                exp_r = (exp_rd_b_q.size() != 0) ? exp_rd_b_q.pop_front() : 8'hxx;
                if (out_data_b !== exp_r) begin
                    errors++;
                    $display("FAIL wrap_rd c=%0d: got %h required %h", c, out_data_b, exp_r);
                end
            end
        end
        done     = 1'b0;
        in_valid = 1'b0;
        checks++;
        if (exp_wr_b_q.size() != 0 || exp_rd_b_q.size() != 0) begin
            errors++;
            $display("FAIL wrap_leftover: wr=%0d rd=%0d required 0 0", exp_wr_b_q.size(), exp_rd_b_q.size());
        end
        exp_wr_b_q.delete();
        exp_rd_b_q.delete();
    endtask

    task automatic test_async_reset();
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            in_valid  = (c < 3);
            in_data   = 8'h99;
            done      = 1'b0;
            out_ready = 1'b1;
            #1;
            mem_update();
        end
        checks++;
        if (busy !== 1'b1 || run_cycles !== 16'd4) begin
            errors++;
            $display("FAIL areset_pre: busy=%b run=%0d required 1 4", busy, run_cycles);
        end
        #1;
        reset = 1'b1;
        #1;
        checks++;
        if ({in_ready, out_valid, start, mem_wr_en, mem_addr, mem_wr_data, busy, timed_out, run_cycles} !== 38'd0 ||
            {busy_b, start_b, mem_wr_en_b, out_valid_b} !== 4'd0) begin
            errors++;
            $display("FAIL areset_outputs: got %h required 0", {in_ready, out_valid, start, mem_wr_en, mem_addr, mem_wr_data, busy, timed_out, run_cycles});
        end
        @(negedge clk);
        reset = 1'b0;
        done  = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            #1;
            checks++;
            if ({start, mem_wr_en, out_valid, busy} !== 4'd0) begin
                errors++;
                $display("FAIL areset_quiet c=%0d: start/wr/out_valid/busy=%b required 0000", c, {start, mem_wr_en, out_valid, busy});
            end
        end
        done = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b0;
        done      = 1'b0;
        for (int i = 0; i < 256; i++) begin
            mem[i]   = 8'h00;
            mem_b[i] = 8'h00;
        end
        repeat (2) @(negedge clk);
        test_reset();
        test_nominal();
        test_stale_done();
        test_timeout();
        test_backpressure();
        test_addr_wrap();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
